// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage; owns the HI/LO registers.
// One shift-add (multiply) or restoring (divide) step per cycle, WIDTH steps per operation.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  logic                 r_is_div;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_opa_raw;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH-1:0]     w_div_diff;
  logic                 w_div_ok;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign w_last = (r_count == LAST_CNT);

  // Operand magnitudes and sign flags; op[0] selects the signed variants.
  always_comb begin
    w_sa    = op[0] & srca[WIDTH-1];
    w_sb    = op[0] & srcb[WIDTH-1];
    w_mag_a = srca;
    w_mag_b = srcb;
    if (w_sa) begin
      w_mag_a = -srca;
    end else begin
      w_mag_a = srca;
    end
    if (w_sb) begin
      w_mag_b = -srcb;
    end else begin
      w_mag_b = srcb;
    end
  end

  // One iteration of either algorithm; r_acc holds {product} or {remainder, quotient}.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                  (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_acc   = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    w_div_acc   = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    if (w_div_ok) begin
      w_div_acc = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_acc = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
    if (r_is_div) begin
      w_acc_nxt = w_div_acc;
    end else begin
      w_acc_nxt = w_mul_acc;
    end
  end

  // Sign-corrected result from the final step; divide-by-zero returns the raw dividend in HI.
  always_comb begin
    w_res_hi = {WIDTH{1'b0}};
    w_res_lo = {WIDTH{1'b0}};
    if (r_is_div) begin
      if (r_dz) begin
        w_res_lo = {WIDTH{1'b1}};
        w_res_hi = r_opa_raw;
      end else begin
        w_res_lo = (r_sa ^ r_sb) ? -w_div_acc[WIDTH-1:0] : w_div_acc[WIDTH-1:0];
        w_res_hi = r_sa ? -w_div_acc[2*WIDTH-1:WIDTH] : w_div_acc[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (r_sa ^ r_sb) begin
        {w_res_hi, w_res_lo} = -w_mul_acc;
      end else begin
        {w_res_hi, w_res_lo} = w_mul_acc;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, HI/LO and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= {CNT_W{1'b0}};
      r_is_div  <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dz      <= 1'b0;
      r_opa_raw <= {WIDTH{1'b0}};
      r_opnd    <= {WIDTH{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count   <= {CNT_W{1'b0}};
            r_is_div  <= op[1];
            r_sa      <= w_sa;
            r_sb      <= w_sb;
            r_dz      <= op[1] & (srcb == {WIDTH{1'b0}});
            r_opa_raw <= srca;
            r_opnd    <= op[1] ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
          end
        end
        ST_RUN: begin
          if (!flush) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: begin
        end
      endcase
      // MTHI/MTLO are the younger instruction, so outside RUN they win over any result.
      if (r_state != ST_RUN) begin
        if (hi_we) begin
          r_hi <= srca;
        end
        if (lo_we) begin
          r_lo <= srca;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hi_we;
  logic        lo_we;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else            p = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  function automatic logic [31:0] pick(input bit is_divisor);
    case ($urandom_range(0, 7))
      0:       pick = 32'd0;
      1:       pick = 32'h8000_0000;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = is_divisor ? 32'($urandom_range(1, 15)) : 32'd1;
      default: pick = 32'($urandom);
    endcase
  endfunction

  // Launches one operation from IDLE and collects busy length and the values at done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output logic dn, output logic [31:0] h, output logic [31:0] l);
    @(posedge clk); #1;
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      @(posedge clk); #1;
    end
    dn = done;
    h  = hi;
    l  = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'd0; srca = 32'd0; srcb = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h exp 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
                              32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] t_b  [7] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                              32'd0, 32'd1, 32'hFFFF_FFF9};
    logic [31:0] t_lo [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int          nb;
    logic        dn;
    logic [31:0] h;
    logic [31:0] l;
    for (int i = 0; i < 7; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], nb, dn, h, l);
      n_cmp++; if (nb != 32) begin n_bad++; $display("FAIL dir%0d_busy_len got %0d exp 32", i, nb); end
      n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL dir%0d_done got %b exp 1", i, dn); end
      n_cmp++; if (h !== t_hi[i]) begin n_bad++; $display("FAIL dir%0d_hi got %h exp %h", i, h, t_hi[i]); end
      n_cmp++; if (l !== t_lo[i]) begin n_bad++; $display("FAIL dir%0d_lo got %h exp %h", i, l, t_lo[i]); end
    end
  endtask

  task automatic test_random();
    int          nb;
    logic        dn;
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] eh;
    logic [31:0] el;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick(1'b0);
      b = pick(1'b1);
      ref_model(o, a, b, eh, el);
      do_op(o, a, b, nb, dn, h, l);
      n_cmp++; if (nb != 32) begin n_bad++; $display("FAIL rnd%0d_busy_len got %0d exp 32", i, nb); end
      n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_done got %b exp 1", i, dn); end
      n_cmp++; if (h !== eh) begin n_bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h exp %h", i, o, a, b, h, eh); end
      n_cmp++; if (l !== el) begin n_bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h exp %h", i, o, a, b, l, el); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  task automatic test_flush();
    bit seen_done;
    @(posedge clk); #1;
    hi_we = 1'b1; srca = 32'h1111_2222;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; srca = 32'h3333_4444;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_cmp++; if (hi !== 32'h1111_2222) begin n_bad++; $display("FAIL mthi got %h exp 11112222", hi); end
    n_cmp++; if (lo !== 32'h3333_4444) begin n_bad++; $display("FAIL mtlo got %h exp 33334444", lo); end
    op = 2'd0; srca = 32'd5; srcb = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    hi_we = 1'b1; lo_we = 1'b1; srca = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b exp 0", busy); end
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done) begin n_bad++; $display("FAIL flush_no_done got 1 exp 0"); end
    n_cmp++; if (hi !== 32'h1111_2222) begin n_bad++; $display("FAIL flush_hi got %h exp 11112222", hi); end
    n_cmp++; if (lo !== 32'h3333_4444) begin n_bad++; $display("FAIL flush_lo got %h exp 33334444", lo); end
  endtask

  task automatic test_start_ignored();
    int nb;
    op = 2'd0; srca = 32'd5; srcb = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 5) begin srca = 32'd9; srcb = 32'd9; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++; if (nb != 32) begin n_bad++; $display("FAIL ign_busy_len got %0d exp 32", nb); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ign_done got %b exp 1", done); end
    n_cmp++; if (lo !== 32'd30) begin n_bad++; $display("FAIL ign_lo got %h exp 0000001e", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL ign_hi got %h exp 0", hi); end
    srca = 32'd7; srcb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_start busy got %b exp 0", busy); end
  endtask

  task automatic test_mt_with_start();
    int          nb;
    logic [31:0] eh;
    logic [31:0] el;
    ref_model(2'd1, 32'h0000_00AA, 32'd3, eh, el);
    @(posedge clk); #1;
    op = 2'd1; srca = 32'h0000_00AA; srcb = 32'd3; start = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    n_cmp++; if (lo !== 32'h0000_00AA) begin n_bad++; $display("FAIL mtlo_start_lo got %h exp 000000aa", lo); end
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin nb++; @(posedge clk); #1; end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mtlo_start_done got %b exp 1", done); end
    n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL mtlo_start_res_lo got %h exp %h", lo, el); end
    n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL mtlo_start_res_hi got %h exp %h", hi, eh); end
  endtask

  task automatic test_done_write();
    int          nb;
    logic        dn;
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    a = 32'($urandom);
    b = 32'($urandom);
    ref_model(2'd0, a, b, eh, el);
    do_op(2'd0, a, b, nb, dn, h, l);
    n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL dw_done got %b exp 1", dn); end
    hi_we = 1'b1; flush = 1'b1; srca = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; flush = 1'b0;
    n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL dw_hi got %h exp cafef00d", hi); end
    n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL dw_lo got %h exp %h", lo, el); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dw_busy got %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    int          nb;
    logic        dn;
    logic [31:0] h;
    logic [31:0] l;
    @(posedge clk); #1;
    op = 2'd3; srca = 32'hFFFF_0000; srcb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy got %b exp 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL areset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL areset_lo got %h exp 0", lo); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL areset_done got %b exp 0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(2'd2, 32'd100, 32'd7, nb, dn, h, l);
    n_cmp++; if (l !== 32'd14 || h !== 32'd2) begin
      n_bad++; $display("FAIL areset_recover got hi=%h lo=%h exp hi=00000002 lo=0000000e", h, l);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_mt_with_start();
    test_done_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
